// File: rtl/core_boot_pkg.sv
// rtl/core_boot_pkg.sv - shared state encodings and helpers for the boot controller
//
// Purpose: FSM state encoding and the beats-per-word helper used by the top
//          and by the beat packer.
// Ports:   none (package).

package core_boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Beats per instruction word; DATA_W must be an integer multiple of IN_W.
  function automatic int calc_bpw(input int data_w, input int in_w);
    return data_w / in_w;
  endfunction

endpackage

// File: rtl/core_boot_ctrl_packer.sv
// rtl/core_boot_ctrl_packer.sv - assembles narrow load-stream beats into instruction words
//
// Purpose: beat counter plus assembly register. Beat k lands in bits
//          [k*IN_W +: IN_W] (little-endian within the word).
// Ports:
//   clk        in   1       system clock
//   rstn       in   1       asynchronous active-low reset
//   clr        in   1       synchronous clear of beat counter and assembly register
//   beat_valid in   1       a beat is accepted this cycle
//   beat_data  in   IN_W    accepted beat
//   word_valid out  1       last beat of a word is accepted this cycle (combinational)
//   word_data  out  DATA_W  complete word including the beat accepted this cycle

module core_boot_packer
  import core_boot_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              beat_valid,
  input  logic [IN_W-1:0]   beat_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data
);

  localparam int BPW   = calc_bpw(DATA_W, IN_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] w_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (beat_valid) begin
      r_asm[int'(r_cnt) * IN_W +: IN_W] <= beat_data;
      r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // The final beat is merged combinationally so the top can register the
  // whole word in the cycle right after that beat's handshake.
  always_comb begin
    w_word = r_asm;
    w_word[(BPW - 1) * IN_W +: IN_W] = beat_data;
  end

  assign word_valid = beat_valid && (r_cnt == LAST_BEAT);
  assign word_data  = w_word;

endmodule

// File: rtl/core_boot_ctrl.sv
// rtl/core_boot_ctrl.sv - boot sequencer: loads instruction memory, then releases core reset
//
// Purpose: holds the core in reset, streams a program image into the
//          instruction-memory write port, then releases core reset RST_HOLD
//          cycles after the load. Supports skip-load boot and run-time reload.
// Ports:
//   clk          in   1         system clock
//   rstn         in   1         asynchronous active-low reset
//   boot_skip    in   1         skip loading (sampled in IDLE only)
//   load_len     in   ADDR_W+1  words to load, 0 = 2**ADDR_W (sampled on LOAD entry)
//   reload_req   in   1         reload pulse, honoured in RUN only
//   s_valid      in   1         load-stream beat valid
//   s_data       in   IN_W      load-stream beat
//   s_ready      out  1         high in LOAD
//   mem_we       out  1         instruction-memory write enable (registered)
//   mem_addr     out  ADDR_W    word address (registered)
//   mem_wdata    out  DATA_W    word data (registered)
//   core_rstn    out  1         core reset, active low (registered)
//   boot_done    out  1         high in RUN (registered)
//   words_loaded out  ADDR_W+1  words written since the last LOAD entry

module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int IN_W     = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              boot_skip,
  input  logic [ADDR_W:0]   load_len,
  input  logic              reload_req,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rstn,
  output logic              boot_done,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_words;
  logic [HOLD_W-1:0]   r_hold;

  logic                w_accept;
  logic                w_clr;
  logic                w_word_valid;
  logic [DATA_W-1:0]   w_word_data;
  logic [ADDR_W:0]     w_words_inc;
  logic [ADDR_W:0]     w_len_eff;

  assign s_ready      = (r_state == ST_LOAD);
  assign w_accept     = s_valid && s_ready;
  assign words_loaded = r_words;
  assign w_words_inc  = r_words + ONE_W;
  assign w_len_eff    = (load_len == '0) ? MAX_LEN : load_len;

  // Packer restarts on every LOAD entry so a stale partial word never leaks
  // into a reload.
  assign w_clr = ((r_state == ST_IDLE) && !boot_skip) ||
                 ((r_state == ST_RUN) && reload_req);

  core_boot_packer #(
    .IN_W   (IN_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (w_clr),
    .beat_valid (w_accept),
    .beat_data  (s_data),
    .word_valid (w_word_valid),
    .word_data  (w_word_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_words   <= '0;
      r_hold    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rstn <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (boot_skip) begin
            r_state <= ST_HOLD;
            r_hold  <= HOLD_W'(1);
          end else begin
            r_state <= ST_LOAD;
            r_len   <= w_len_eff;
            r_words <= '0;
          end
        end
        ST_LOAD: begin
          if (w_word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_words[ADDR_W-1:0];
            mem_wdata <= w_word_data;
            r_words   <= w_words_inc;
            // r_len <= 2**ADDR_W, so the address never wraps within a load.
            if (w_words_inc == r_len) begin
              r_state <= ST_HOLD;
              r_hold  <= HOLD_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // The entry cycle counts as hold cycle 1.
          if (r_hold == HOLD_W'(RST_HOLD)) begin
            r_state   <= ST_RUN;
            core_rstn <= 1'b1;
            boot_done <= 1'b1;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (reload_req) begin
            r_state   <= ST_LOAD;
            core_rstn <= 1'b0;
            boot_done <= 1'b0;
            r_len     <= w_len_eff;
            r_words   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_boot_ctrl.sv
// tb/tb_core_boot_ctrl.sv - self-checking bench for core_boot_ctrl

module tb_core_boot_ctrl;

  localparam int RST_HOLD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        rstn = 1'b0;
  logic        boot_skip = 1'b0;
  logic [10:0] load_len = '0;
  logic        reload_req = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_we, core_rstn, boot_done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  // Word-wide, 16-deep DUT
  logic        rstn6 = 1'b0;
  logic        boot_skip6 = 1'b0;
  logic [4:0]  load_len6 = '0;
  logic        reload_req6 = 1'b0;
  logic        s_valid6 = 1'b0;
  logic [31:0] s_data6 = '0;
  logic        s_ready6, mem_we6, core_rstn6, boot_done6;
  logic [3:0]  mem_addr6;
  logic [31:0] mem_wdata6;
  logic [4:0]  words_loaded6;

  core_boot_ctrl dut (
    .clk(clk), .rstn(rstn), .boot_skip(boot_skip), .load_len(load_len),
    .reload_req(reload_req), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rstn(core_rstn), .boot_done(boot_done), .words_loaded(words_loaded)
  );

  core_boot_ctrl #(.ADDR_W(4), .DATA_W(32), .IN_W(32), .RST_HOLD(RST_HOLD)) dut6 (
    .clk(clk), .rstn(rstn6), .boot_skip(boot_skip6), .load_len(load_len6),
    .reload_req(reload_req6), .s_valid(s_valid6), .s_data(s_data6), .s_ready(s_ready6),
    .mem_we(mem_we6), .mem_addr(mem_addr6), .mem_wdata(mem_wdata6),
    .core_rstn(core_rstn6), .boot_done(boot_done6), .words_loaded(words_loaded6)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int we6_cnt = 0;
  int we6_first = -1;
  int we6_last = 0;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [10:0] words;
    logic        rdy;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_write(input string who, input int a, input logic [31:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_write: got addr %0h data %0h expected no write", who, a, d);
    end else begin
      e = exp_q.pop_front();
      chk({who, "_wr_addr"}, 64'(a), 64'(e.addr));
      chk({who, "_wr_data"}, 64'(d), 64'(e.data));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1) begin
      check_write("dut", int'(mem_addr), mem_wdata);
      last_we_cyc = cyc;
    end
    if (mem_we6 === 1'b1) begin
      check_write("dut6", int'(mem_addr6), mem_wdata6);
      we6_cnt++;
      if (we6_first < 0) we6_first = cyc;
      we6_last = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_core_rstn"}, 64'(core_rstn), 64'd0);
    chk({tag, "_boot_done"}, 64'(boot_done), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  // Holds reset, checks the reset state, then releases just after a rising edge.
  task automatic do_reset(input string tag, input logic skip, input logic [10:0] len);
    rstn = 1'b0;
    reload_req = 1'b0;
    s_valid = 1'b0;
    boot_skip = skip;
    load_len = len;
    repeat (2) step();
    check_zero(tag);
    rstn = 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] d);
    int n;
    s_valid = 1'b1;
    s_data = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("beat_ready_timeout", 64'(s_ready), 64'd1);
    step();
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (core_rstn !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_core_rstn_run"}, 64'(core_rstn), 64'd1);
  endtask

  initial begin
    int n;
    logic seen_ready;
    int mk, maddr;
    logic [31:0] mword;
    logic [31:0] d6;

    // ---- Test 2: skip-load boot (also covers reset state) ----
    do_reset("rst", 1'b1, 11'd5);
    s_valid = 1'b1;
    s_data = 8'h5A;
    n = 0;
    seen_ready = 1'b0;
    while (core_rstn !== 1'b1 && n < 30) begin
      step();
      n++;
      if (s_ready === 1'b1) seen_ready = 1'b1;
    end
    chk("t2_rise_cycles", 64'(n), 64'(1 + RST_HOLD));
    chk("t2_ready_seen", 64'(seen_ready), 64'd0);
    chk("t2_boot_done", 64'(boot_done), 64'd1);
    chk("t2_words_loaded", 64'(words_loaded), 64'd0);

    // ---- Test 1: three words of 0x13, full-rate stream ----
    do_reset("t1rst", 1'b0, 11'd3);
    for (int w = 0; w < 3; w++) begin
      send_beat(8'h13);
      send_beat(8'h00);
      send_beat(8'h00);
      push(w, 32'h0000_0013);
      send_beat(8'h00);
    end
    wait_run("t1");
    chk("t1_hold_cycles", 64'(cyc - last_we_cyc), 64'(RST_HOLD));
    chk("t1_boot_done", 64'(boot_done), 64'd1);
    chk("t1_words_loaded", 64'(words_loaded), 64'd3);
    chk("t1_ready_in_run", 64'(s_ready), 64'd0);

    // ---- Test 4: reload in RUN with s_valid already high ----
    load_len = 11'd1;
    reload_req = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hD4;
    push(0, 32'hA1B2_C3D4);
    step();
    reload_req = 1'b0;
    chk("t4_core_rstn", 64'(core_rstn), 64'd0);
    chk("t4_boot_done", 64'(boot_done), 64'd0);
    chk("t4_words_restart", 64'(words_loaded), 64'd0);
    chk("t4_ready", 64'(s_ready), 64'd1);
    send_beat(8'hD4);
    send_beat(8'hC3);
    send_beat(8'hB2);
    send_beat(8'hA1);
    wait_run("t4");
    chk("t4_words_loaded", 64'(words_loaded), 64'd1);

    // ---- Test 3: stalled stream, table-driven per-cycle vectors ----
    tbl[0]  = '{1'b1, 8'hAA, 1'b0, 11'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 11'd0, 1'b1};
    tbl[2]  = '{1'b1, 8'hBB, 1'b0, 11'd0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 11'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'hCC, 1'b0, 11'd0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 11'd0, 1'b1};
    tbl[6]  = '{1'b1, 8'hDD, 1'b1, 11'd1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 11'd1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1};
    tbl[10] = '{1'b1, 8'h22, 1'b0, 11'd1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1};
    tbl[12] = '{1'b1, 8'h33, 1'b0, 11'd1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1};
    tbl[14] = '{1'b1, 8'h44, 1'b1, 11'd2, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 11'd2, 1'b0};
    tbl[16] = '{1'b1, 8'h99, 1'b0, 11'd2, 1'b0};
    do_reset("t3rst", 1'b0, 11'd2);
    step();
    mk = 0;
    maddr = 0;
    mword = '0;
    for (int i = 0; i < 17; i++) begin
      s_valid = tbl[i].v;
      s_data = tbl[i].d;
      if (tbl[i].v && maddr < 2) begin
        mword[mk*8 +: 8] = tbl[i].d;
        if (mk == 3) begin
          push(maddr, mword);
          maddr++;
          mk = 0;
        end else begin
          mk++;
        end
      end
      step();
      chk($sformatf("t3_row%0d_we", i), 64'(mem_we), 64'(tbl[i].we));
      chk($sformatf("t3_row%0d_words", i), 64'(words_loaded), 64'(tbl[i].words));
      chk($sformatf("t3_row%0d_ready", i), 64'(s_ready), 64'(tbl[i].rdy));
    end
    chk("t3_model_words", 64'(maddr), 64'd2);

    // ---- Test 5: asynchronous reset mid-load, then a fresh load ----
    do_reset("t5rst", 1'b0, 11'd4);
    push(0, 32'h0403_0201);
    send_beat(8'h01);
    send_beat(8'h02);
    send_beat(8'h03);
    send_beat(8'h04);
    send_beat(8'h05);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("t5_async");
    s_valid = 1'b0;
    do_reset("t5rst2", 1'b0, 11'd1);
    push(0, 32'h5566_7788);
    send_beat(8'h88);
    send_beat(8'h77);
    send_beat(8'h66);
    send_beat(8'h55);
    wait_run("t5");
    chk("t5_words_loaded", 64'(words_loaded), 64'd1);

    // ---- Test 6: word-wide beats, load_len=0 means the full 16-word space ----
    s_valid = 1'b0;
    load_len6 = 5'd0;
    rstn6 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d6 = $urandom;
      push(i, d6);
      s_valid6 = 1'b1;
      s_data6 = d6;
      n = 0;
      while (s_ready6 !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk("t6_ready_timeout", 64'(s_ready6), 64'd1);
      step();
    end
    s_data6 = 32'hDEAD_BEEF;
    n = 0;
    while (core_rstn6 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t6_core_rstn_run", 64'(core_rstn6), 64'd1);
    chk("t6_boot_done", 64'(boot_done6), 64'd1);
    chk("t6_words_loaded", 64'(words_loaded6), 64'd16);
    chk("t6_write_count", 64'(we6_cnt), 64'd16);
    chk("t6_consecutive", 64'(we6_last - we6_first), 64'd15);
    s_valid6 = 1'b0;

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
